// File: rtl/regbank8_wr.sv
// Write side of an 8 x WIDTH register bank: one-entry pending buffer behind a valid/ready
// handshake, one-hot commit into the array, and two combinational read ports with optional bypass.
module regbank8_wr #(
   parameter int WIDTH  = 16,
   parameter bit BYPASS = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [2:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             stall,
   input  logic [2:0]       rd_addr1,
   input  logic [2:0]       rd_addr2,
   output logic [WIDTH-1:0] rd_data1,
   output logic [WIDTH-1:0] rd_data2,
   output logic [7:0]       dirty,
   output logic [7:0]       wr_count
);

   logic [WIDTH-1:0] regs [8];
   logic             pend_valid;
   logic [2:0]       pend_addr;
   logic [WIDTH-1:0] pend_data;
   logic             accept;
   logic             commit;
   logic [7:0]       wr_en;

   // The buffer can take a new entry when empty or when its current entry drains this edge.
   assign wr_ready = !pend_valid || !stall;
   assign accept   = wr_valid && wr_ready;
   assign commit   = pend_valid && !stall;

   // NOTE: default assigned first so every path drives wr_en and no latch is inferred.
   always_comb begin
      wr_en = '0;
      if (commit) wr_en[pend_addr] = 1'b1;
   end

   // NOTE: non-blocking assignments in clocked blocks so all state updates see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
      end else if (accept) begin
         pend_valid <= 1'b1;
         pend_addr  <= wr_addr;
         pend_data  <= wr_data;
      end else if (commit) begin
         pend_valid <= 1'b0;
      end
   end

   // NOTE: the array is reset because reads after reset must return zero.
   for (genvar g = 0; g < 8; g++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)        regs[g] <= '0;
         else if (wr_en[g]) regs[g] <= pend_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dirty    <= 8'h00;
         wr_count <= 8'h00;
      end else if (commit) begin
         dirty    <= dirty | wr_en;
         wr_count <= wr_count + 8'd1;
      end
   end

   always_comb begin
      rd_data1 = regs[rd_addr1];
      rd_data2 = regs[rd_addr2];
      if (BYPASS && pend_valid && (rd_addr1 == pend_addr)) rd_data1 = pend_data;
      if (BYPASS && pend_valid && (rd_addr2 == pend_addr)) rd_data2 = pend_data;
   end

endmodule

// File: tb/tb_regbank8_wr.sv
// Directed bench for regbank8_wr: one instance with bypass and one without share all inputs,
// so the array contents are observable while an entry is pending.
module tb_regbank8_wr;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             wr_valid;
   logic [2:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             stall;
   logic [2:0]       rd_addr1;
   logic [2:0]       rd_addr2;

   logic             wr_ready_b1, wr_ready_b0;
   logic [WIDTH-1:0] rd_data1_b1, rd_data2_b1, rd_data1_b0, rd_data2_b0;
   logic [7:0]       dirty_b1, dirty_b0, wr_count_b1, wr_count_b0;

   int checks;
   int failures;

   regbank8_wr #(.WIDTH(WIDTH), .BYPASS(1'b1)) dut_b1 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_b1),
      .wr_addr(wr_addr), .wr_data(wr_data), .stall(stall),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1_b1), .rd_data2(rd_data2_b1),
      .dirty(dirty_b1), .wr_count(wr_count_b1)
   );

   regbank8_wr #(.WIDTH(WIDTH), .BYPASS(1'b0)) dut_b0 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_b0),
      .wr_addr(wr_addr), .wr_data(wr_data), .stall(stall),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1_b0), .rd_data2(rd_data2_b0),
      .dirty(dirty_b0), .wr_count(wr_count_b0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      stall    = 1'b0;
      rd_addr1 = '0;
      rd_addr2 = '0;

      // Reset state, both read ports swept over all addresses
      #2;
      for (int i = 0; i < 8; i++) begin
         rd_addr1 = 3'(i);
         rd_addr2 = 3'(7 - i);
         #1;
         check("rst_rd1", 32'(rd_data1_b1), 32'h0);
         check("rst_rd2", 32'(rd_data2_b1), 32'h0);
      end
      check("rst_ready", 32'(wr_ready_b1), 32'h1);
      check("rst_dirty", 32'(dirty_b1), 32'h00);
      check("rst_count", 32'(wr_count_b1), 32'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Single write, no stall
      wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
      tick();
      wr_valid = 1'b0;
      tick();
      rd_addr1 = 3'd5;
      #1;
      check("single_reg5", 32'(rd_data1_b0), 32'hBEEF);
      check("single_dirty", 32'(dirty_b1), 32'h20);
      check("single_count", 32'(wr_count_b1), 32'h01);
      for (int i = 0; i < 8; i++) begin
         if (i != 5) begin
            rd_addr2 = 3'(i);
            #1;
            check("single_other", 32'(rd_data2_b0), 32'h0);
         end
      end

      // Stall hold and bypass
      wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234; stall = 1'b0;
      tick();
      wr_valid = 1'b0; stall = 1'b1; rd_addr1 = 3'd2;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("stall_ready", 32'(wr_ready_b1), 32'h0);
         check("stall_bypass", 32'(rd_data1_b1), 32'h1234);
         check("stall_array", 32'(rd_data1_b0), 32'h0);
         check("stall_count", 32'(wr_count_b1), 32'h01);
         tick();
      end
      stall = 1'b0;
      #1;
      check("unstall_ready", 32'(wr_ready_b1), 32'h1);
      tick();
      check("unstall_reg2", 32'(rd_data1_b0), 32'h1234);
      check("unstall_dirty", 32'(dirty_b1), 32'h24);
      check("unstall_count", 32'(wr_count_b1), 32'h02);

      // Streaming eight writes, one per cycle
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 16'(16'h1000 + i);
         #1;
         check("stream_ready", 32'(wr_ready_b1), 32'h1);
         tick();
      end
      wr_valid = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         rd_addr1 = 3'(i);
         #1;
         check("stream_reg", 32'(rd_data1_b0), 32'h1000 + 32'(i));
      end
      check("stream_dirty", 32'(dirty_b1), 32'hFF);
      check("stream_count", 32'(wr_count_b1), 32'd10);

      // Same-address back-to-back ordering
      wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hAAAA;
      tick();
      wr_data = 16'h5555; rd_addr2 = 3'd3;
      #1;
      check("order_bypass1", 32'(rd_data2_b1), 32'hAAAA);
      tick();
      wr_valid = 1'b0;
      #1;
      check("order_bypass2", 32'(rd_data2_b1), 32'h5555);
      check("order_mid_arr", 32'(rd_data2_b0), 32'hAAAA);
      tick();
      check("order_reg3", 32'(rd_data2_b0), 32'h5555);
      check("order_count", 32'(wr_count_b1), 32'd12);

      // Reset mid-operation drops the pending write
      stall = 1'b1;
      wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF;
      tick();
      wr_valid = 1'b0; rd_addr1 = 3'd7;
      #1;
      check("midrst_pend", 32'(rd_data1_b1), 32'hFFFF);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_bypass", 32'(rd_data1_b1), 32'h0);
      check("midrst_ready", 32'(wr_ready_b1), 32'h1);
      check("midrst_count", 32'(wr_count_b1), 32'h00);
      check("midrst_dirty", 32'(dirty_b1), 32'h00);
      rst_n = 1'b1;
      stall = 1'b0;
      tick();
      tick();
      check("midrst_reg7", 32'(rd_data1_b0), 32'h0);
      check("midrst_nocommit", 32'(wr_count_b1), 32'h00);

      // 256 commits wrap the counter
      for (int i = 0; i < 256; i++) begin
         wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 16'(i);
         tick();
      end
      wr_valid = 1'b0;
      check("wrap_255", 32'(wr_count_b1), 32'd255);
      tick();
      check("wrap_0", 32'(wr_count_b1), 32'd0);
      check("wrap_dirty", 32'(dirty_b1), 32'hFF);
      #1;
      check("wrap_reg7", 32'(rd_data1_b0), 32'h00FF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
